fetch_queue: RTL and testbench

//  Parametrised successor to the single-cycle fetch front end: owns the PC, issues

---
 rtl/fetch_queue_pkg.sv | 26 ++
 rtl/fetch_queue_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 148 ++++++++++++++
 tb/tb_fetch_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the fetch queue: FSM state encoding,
// queue entry layout and counter width helper.
package fetch_queue_pkg;

  // Default instruction / PC width of the fetch front end
  localparam int FQ_XLEN = 16;

  // Fetch FSM states
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } fq_state_e;

  // One buffered instruction together with the PC it was fetched from
  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
  } fq_entry_t;

  // Occupancy counters need one extra bit to represent a full queue
  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer holding fetched {pc, instr} pairs for the fetch queue.
// Read/write pointers wrap naturally because DEPTH is a power of two;
// a synchronous flush empties the buffer in one cycle.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int XLEN  = FQ_XLEN,
  parameter int DEPTH = 4,
  localparam int CNT_W = fq_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [XLEN-1:0]  push_pc,
  input  logic [XLEN-1:0]  push_instr,
  input  logic             pop,
  output logic [XLEN-1:0]  head_pc,
  output logic [XLEN-1:0]  head_instr,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; an empty queue never exposes its contents
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues one request at a time to a
// latency-tolerant instruction memory and buffers returned words for decode.
// A redirect flushes the queue and toggles the epoch so the response of a
// request issued before the redirect is discarded.
// Optional build macro FETCH_QUEUE_PERF_EN adds saturating stall/flush counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = FQ_XLEN,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt_sys,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [15:0]     perf_flush_cnt
`endif
);

  localparam int CNT_W = fq_cnt_w(DEPTH);

  fq_state_e        state;
  fq_state_e        state_nxt;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  req_pc;
  logic             outstanding;
  logic             epoch;
  logic             req_epoch;
  logic             issue;
  logic             resp_take;
  logic             resp_push;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  head_pc;
  logic [XLEN-1:0]  head_instr;

  // A queue slot is reserved at issue time, so a request only goes out when
  // the queue has room for its response.
  assign issue     = rst && (state == S_ISSUE) && !halt_sys && !redirect_valid
                     && (count < CNT_W'(DEPTH));
  assign resp_take = outstanding && imem_rvalid;
  assign resp_push = resp_take && (req_epoch == epoch) && !redirect_valid;
  assign pop       = dec_valid && dec_ready && !redirect_valid;

  assign imem_req  = issue;
  assign imem_addr = pc;
  assign dec_valid = (count != '0);
  assign dec_instr = dec_valid ? head_instr : '0;
  assign dec_pc    = dec_valid ? head_pc    : '0;

  // Next-state logic for the single-outstanding-request fetch FSM
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (issue) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_take) begin
          state_nxt = S_ISSUE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC, epoch and outstanding-request tracking; redirect wins over issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      epoch       <= 1'b0;
      outstanding <= 1'b0;
      req_epoch   <= 1'b0;
      req_pc      <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc    <= redirect_pc;
        epoch <= ~epoch;
      end else if (issue) begin
        pc <= pc + XLEN'(PC_STEP);
      end
      if (issue) begin
        outstanding <= 1'b1;
        req_epoch   <= epoch;
        req_pc      <= pc;
      end else if (resp_take) begin
        outstanding <= 1'b0;
      end
    end
  end

  fetch_queue_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (resp_push),
    .push_pc    (req_pc),
    .push_instr (imem_rdata),
    .pop        (pop),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count)
  );

`ifdef FETCH_QUEUE_PERF_EN
  // Saturating counters of decode back-pressure cycles and redirects
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (dec_valid && !dec_ready && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (redirect_valid && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue. A reference model of the
// fetch stream pushes expected {pc, instr} entries; a monitor compares them
// whenever decode accepts the queue head.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int              XLEN     = 16;
  localparam int              DEPTH    = 4;
  localparam int              PC_STEP  = 2;
  localparam logic [XLEN-1:0] RESET_PC = 16'h0000;
  localparam int              NCYC     = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic            halt_sys;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]     perf_stall_cnt;
  logic [15:0]     perf_flush_cnt;
`endif

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .halt_sys       (halt_sys),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pops   = 0;

  // Scoreboard of words decode should receive, oldest first
  fq_entry_t exp_q[$];
  int        occ_seen    = 0;
  bit        model_valid = 1'b0;
  bit        was_reset   = 1'b0;

  // Reference fetch model
  logic [XLEN-1:0] exp_pc   = RESET_PC;
  logic [XLEN-1:0] m_req_pc = '0;
  bit              m_out    = 1'b0;
  bit              m_killed = 1'b0;
  bit              m_idle   = 1'b1;

  // Instruction memory model: one request in flight, latency 1..3 cycles
  bit              mem_pend     = 1'b0;
  bit              mem_stale    = 1'b0;
  int              mem_resp_cyc = 0;
  logic [XLEN-1:0] mem_data     = '0;

  int halt_left  = 0;
  int stall_left = 0;

  // Record one comparison and report it when it does not hold
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Drive control inputs and the memory response for the current cycle
  task automatic applyStimulus();
    int          mode;
    logic [31:0] r;
    mode = (cyc / 300) % 4;

    if (cyc <= 3) begin
      rst = 1'b0;
    end else if (mode == 3 && m_out && $urandom_range(0, 30) == 0) begin
      rst = 1'b0;
    end else begin
      rst = 1'b1;
    end

    if (halt_left > 0) begin
      halt_sys = 1'b1;
      halt_left--;
    end else begin
      halt_sys = 1'b0;
      if (mode >= 2 && $urandom_range(0, 25) == 0) halt_left = 5;
    end

    if (mode == 0) begin
      dec_ready = 1'b1;
    end else if (mode == 1) begin
      if (stall_left > 0) begin
        dec_ready = 1'b0;
        stall_left--;
      end else begin
        dec_ready = 1'b1;
        if ($urandom_range(0, 10) == 0) stall_left = $urandom_range(5, 15);
      end
    end else begin
      dec_ready = ($urandom_range(0, 3) != 0);
    end

    redirect_valid = (mode >= 2) && ($urandom_range(0, 18) == 0);
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       redirect_pc = 16'h0100;
      1:       redirect_pc = 16'hFFFC;
      2:       redirect_pc = 16'hFFFE;
      default: redirect_pc = {r[15:1], 1'b0};
    endcase

    imem_rvalid = 1'b0;
    imem_rdata  = XLEN'($urandom);
    if (!rst) begin
      if (mem_pend) begin
        mem_pend  = 1'b0;
        mem_stale = 1'b1;
      end
    end else if (mem_stale) begin
      imem_rvalid = 1'b1;
      mem_stale   = 1'b0;
    end else if (mem_pend && cyc == mem_resp_cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data;
      mem_pend    = 1'b0;
    end
  endtask

  // Monitor: compare the queue head whenever decode accepts it
  task automatic checkOutput();
    fq_entry_t e;
    if (!model_valid) return;
    if (was_reset) begin
      check("reset_dec_pc", 32'(dec_pc), 32'h0);
      check("reset_dec_instr", 32'(dec_instr), 32'h0);
      check("reset_imem_addr", 32'(imem_addr), 32'(RESET_PC));
    end
    occ_seen = exp_q.size();
    check("dec_valid", 32'(dec_valid), 32'(occ_seen != 0));
    if (dec_valid && dec_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dec_pc", 32'(dec_pc), 32'(e.pc));
      check("dec_instr", 32'(dec_instr), 32'(e.instr));
      pops++;
    end
  endtask

  // Reference model: what the fetch unit must do in this cycle
  task automatic updateModel();
    bit        exp_req;
    fq_entry_t e;
    if (!rst) begin
      exp_q.delete();
      m_out       = 1'b0;
      m_killed    = 1'b0;
      exp_pc      = RESET_PC;
      m_idle      = 1'b1;
      model_valid = 1'b1;
      was_reset   = 1'b1;
      return;
    end
    was_reset = 1'b0;
    if (!model_valid) return;

    exp_req = !m_idle && !m_out && !halt_sys && !redirect_valid && (occ_seen < DEPTH);
    m_idle  = 1'b0;
    check("imem_req", 32'(imem_req), 32'(exp_req));

    if (imem_rvalid && m_out) begin
      m_out = 1'b0;
      if (!m_killed && !redirect_valid) begin
        e.pc    = m_req_pc;
        e.instr = imem_rdata;
        exp_q.push_back(e);
      end
    end

    if (imem_req) begin
      check("imem_addr", 32'(imem_addr), 32'(exp_pc));
      m_req_pc     = exp_pc;
      exp_pc       = exp_pc + XLEN'(PC_STEP);
      m_out        = 1'b1;
      m_killed     = 1'b0;
      mem_pend     = 1'b1;
      mem_resp_cyc = cyc + $urandom_range(1, 3);
      mem_data     = XLEN'($urandom);
    end

    if (redirect_valid) begin
      exp_q.delete();
      exp_pc = redirect_pc;
      if (m_out) m_killed = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      checkOutput();
    end
  end

  initial begin
    rst            = 1'b0;
    halt_sys       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    dec_ready      = 1'b0;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      cyc++;
      applyStimulus();
      #2;
      updateModel();
    end
    @(negedge clk);
    check("progress", 32'(pops > 50), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
